if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Parametrised successor fetch stage. Holds the fetch PC, issues reads to the instruction SRAM
//  (1-cycle read latency) and buffers returned words with their PC in a FETCH_DEPTH-entry FIFO.
//  Sits between the branch-resolution bus and ID. Fetch keeps running while ID stalls, until the FIFO is full.
//  Branch redirect flushes queued and in-flight words and flags misaligned fetch PCs to ID.
// PARAMETERS
//  RESET_PC     32'hbfc0_0000  first PC fetched after reset
//  FETCH_DEPTH  4              FIFO entries; power of 2, >=2
//  STALL_W      6              width of stall vector
// PORTS
//  clk              in   1        clock, all state on posedge
//  rst              in   1        synchronous reset, active-high
//  stall            in   STALL_W  [0]=1 blocks new fetch issue; [1]=1 ID not accepting
//  br_e             in   1        redirect strobe from EX
//  br_addr          in   32       redirect target
//  inst_sram_en     out  1        read request this cycle
//  inst_sram_wen    out  4        constant 4'b0
//  inst_sram_addr   out  32       read address (= fetch_pc)
//  inst_sram_wdata  out  32       constant 32'b0
//  inst_sram_rdata  in   32       data for request issued previous cycle
//  if_to_id_valid   out  1        FIFO head valid
//  if_to_id_pc      out  32       PC of head entry
//  if_to_id_inst    out  32       instruction of head entry (0 when excp)
//  if_to_id_excp    out  1        head entry is an address-error (fetch_pc[1:0]!=0)
// BEHAVIOUR
//  Reset values: fetch_pc=RESET_PC, FIFO empty, inflight=0, halted=0. Outputs: inst_sram_en=0, if_to_id_valid=0, pc/inst=0, excp=0.
//  issue = ~rst & ~br_e & ~stall[0] & ~halted & (count + inflight < FETCH_DEPTH).
//  inst_sram_en = issue & (fetch_pc[1:0]==0). Misaligned issue makes no SRAM access.
//  On issue: fetch_pc <= fetch_pc+4 (32-bit wrap). inflight <= 1, with entry {fetch_pc, excp}.
//    If misaligned: halted <= 1 until the next br_e.
//  Cycle after issue, if not killed: push {pc, excp ? 0 : inst_sram_rdata, excp}.
//    The push lands at the clock edge ending that cycle.
//  Latency: rst low in cycle R -> request at R -> head valid at R+2 (no bypass).
//  Sustained throughput: 1 word/cycle while ID accepts.
//  Pop when if_to_id_valid & ~stall[1]. Push and pop in the same cycle are allowed; count is unchanged.
//  Head outputs are driven from FIFO storage at rd_ptr. rd/wr pointers wrap modulo FETCH_DEPTH.
//  Full: the credit rule (count+inflight) prevents overflow. A push to a full FIFO is impossible and is asserted.
//  Empty: if_to_id_valid=0 and pc/inst/excp hold the last read slot (don't-care).
//  br_e (priority over stall and rst-free logic):
//    - FIFO cleared same edge (count=0, pointers=0); a pop that cycle is discarded.
//    - The current in-flight response is killed (not pushed next cycle).
//    - No issue that cycle; fetch_pc <= br_addr; halted <= 0.
//    - First target fetch next cycle if not stalled. Target head valid 2 cycles after that.
//  br_e while stall[0]=1: redirect still taken; issue resumes when stall[0] drops.
//  Reset mid-operation: all state returns to reset values next edge and in-flight data is dropped.
//    First fetch occurs in the first cycle rst is low.
// TESTING
//  1 Reset release, stall=0, rdata=f(addr): en at RESET_PC; head valid 2 cycles later.
//    PCs bfc0_0000, _0004, _0008 pop one per cycle.
//  2 Hold stall[1]=1 for 10 cycles: exactly FETCH_DEPTH (4) entries queue and en drops.
//    Release: 4 in-order pops, then fetch resumes with no gap or duplicate PC.
//  3 br_e with br_addr=bfc0_0100 while FIFO holds 3 entries and one in-flight:
//    valid=0 next cycle; no old PC ever appears; next head pc=bfc0_0100.
//  4 br_addr=bfc0_0102: no SRAM en; one entry pc=bfc0_0102, excp=1, inst=0.
//    No further issue until next br_e.
//  5 stall[0]=1 with stall[1]=0: queue drains, en=0, fetch_pc held.
//    Release: fetch continues at held PC.
//  6 Assert rst for 1 cycle with a full FIFO: valid=0, en=0 during reset; restart at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Fetch stage with a small prefetch FIFO: issues one read per cycle to the instruction
// SRAM, queues returned words with their PC, and flushes everything on a branch redirect.
module if_prefetch_queue #(
    parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
    parameter int          FETCH_DEPTH = 4,
    parameter int          STALL_W     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               br_e,
    input  logic [31:0]        br_addr,
    output logic               inst_sram_en,
    output logic [3:0]         inst_sram_wen,
    output logic [31:0]        inst_sram_addr,
    output logic [31:0]        inst_sram_wdata,
    input  logic [31:0]        inst_sram_rdata,
    output logic               if_to_id_valid,
    output logic [31:0]        if_to_id_pc,
    output logic [31:0]        if_to_id_inst,
    output logic               if_to_id_excp
);

    localparam int            PW    = $clog2(FETCH_DEPTH);
    localparam logic [PW:0]   DEPTH = (PW+1)'(FETCH_DEPTH);

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic          halted_reg, halted_next;
    logic          inflight_reg, inflight_next;
    logic [31:0]   inflight_pc_reg, inflight_pc_next;
    logic          inflight_excp_reg, inflight_excp_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW:0]   count_reg, count_next;

    logic [31:0]   pc_mem   [FETCH_DEPTH];
    logic [31:0]   inst_mem [FETCH_DEPTH];
    logic          excp_mem [FETCH_DEPTH];

    logic          issue;
    logic          aligned;
    logic          push;
    logic          pop;
    logic [31:0]   push_inst;

    always_comb begin
        aligned   = (fetch_pc_reg[1:0] == 2'b00);
        // Credit rule: a slot is reserved for the word already in flight.
        issue     = ~rst & ~br_e & ~stall[0] & ~halted_reg
                    & ((count_reg + (PW+1)'(inflight_reg)) < DEPTH);
        push      = inflight_reg & ~br_e;
        pop       = (count_reg != '0) & ~stall[1] & ~br_e;
        push_inst = inflight_excp_reg ? 32'h0 : inst_sram_rdata;
    end

    always_comb begin
        fetch_pc_next      = fetch_pc_reg;
        halted_next        = halted_reg;
        inflight_next      = issue;
        inflight_pc_next   = inflight_pc_reg;
        inflight_excp_next = inflight_excp_reg;
        rd_ptr_next        = rd_ptr_reg;
        wr_ptr_next        = wr_ptr_reg;
        count_next         = count_reg;

        if (br_e) begin
            fetch_pc_next = br_addr;
            halted_next   = 1'b0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (issue) begin
                fetch_pc_next      = fetch_pc_reg + 32'd4;
                inflight_pc_next   = fetch_pc_reg;
                inflight_excp_next = ~aligned;
                if (!aligned) begin
                    halted_next = 1'b1;
                end
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg      <= RESET_PC;
            halted_reg        <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_pc_reg   <= 32'h0;
            inflight_excp_reg <= 1'b0;
            rd_ptr_reg        <= '0;
            wr_ptr_reg        <= '0;
            count_reg         <= '0;
        end else begin
            fetch_pc_reg      <= fetch_pc_next;
            halted_reg        <= halted_next;
            inflight_reg      <= inflight_next;
            inflight_pc_reg   <= inflight_pc_next;
            inflight_excp_reg <= inflight_excp_next;
            rd_ptr_reg        <= rd_ptr_next;
            wr_ptr_reg        <= wr_ptr_next;
            count_reg         <= count_next;
        end
    end

    // Storage is cleared on reset so the head outputs read zero out of reset.
    generate
        for (genvar gi = 0; gi < FETCH_DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    pc_mem[gi]   <= 32'h0;
                    inst_mem[gi] <= 32'h0;
                    excp_mem[gi] <= 1'b0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    pc_mem[gi]   <= inflight_pc_reg;
                    inst_mem[gi] <= push_inst;
                    excp_mem[gi] <= inflight_excp_reg;
                end
            end
        end
    endgenerate

    generate
        if (STALL_W > 2) begin : g_unused_stall
            logic unused_stall;
            assign unused_stall = ^stall[STALL_W-1:2];
        end
    endgenerate

    assign inst_sram_en    = issue & aligned;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = fetch_pc_reg;
    assign inst_sram_wdata = 32'h0;

    assign if_to_id_valid  = (count_reg != '0);
    assign if_to_id_pc     = pc_mem[rd_ptr_reg];
    assign if_to_id_inst   = inst_mem[rd_ptr_reg];
    assign if_to_id_excp   = excp_mem[rd_ptr_reg];

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_reg == DEPTH)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: expected fetch streams are queued at each
// reset/redirect and compared against every word ID accepts.
module tb_if_prefetch_queue;

    localparam logic [31:0] RPC = 32'hbfc0_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        br_e;
    logic [31:0] br_addr;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'h0;
    logic        if_to_id_valid;
    logic [31:0] if_to_id_pc;
    logic [31:0] if_to_id_inst;
    logic        if_to_id_excp;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pop_cnt  = 0;
    int   en_cnt   = 0;
    int   p0;
    int   e0;

    if_prefetch_queue #(
        .RESET_PC(RPC), .FETCH_DEPTH(4), .STALL_W(6)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_e(br_e), .br_addr(br_addr),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .if_to_id_valid(if_to_id_valid), .if_to_id_pc(if_to_id_pc),
        .if_to_id_inst(if_to_id_inst), .if_to_id_excp(if_to_id_excp)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Instruction SRAM with one-cycle read latency; garbage when not enabled.
    always @(posedge clk) begin
        inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : 32'hdead_beef;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic seg(input logic [31:0] start, input int n);
        exp_t e;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            e.pc   = start + 32'(4 * k);
            e.inst = mem_word(e.pc);
            e.excp = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && inst_sram_en) en_cnt++;
        if (!rst && !br_e && if_to_id_valid && !stall[1]) begin
            pop_cnt++;
            check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                $display("pop pc=%h inst=%h excp=%b", if_to_id_pc, if_to_id_inst, if_to_id_excp);
                check("pop_pc", if_to_id_pc, mon_e.pc);
                check("pop_inst", if_to_id_inst, mon_e.inst);
                check("pop_excp", 32'(if_to_id_excp), 32'(mon_e.excp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = '0; br_e = 1'b0; br_addr = '0;
        // 1: reset release, latency and throughput
        step(3);
        #1;
        check("rst_en", 32'(inst_sram_en), 0);
        check("rst_valid", 32'(if_to_id_valid), 0);
        check("rst_pc", if_to_id_pc, 0);
        rst = 1'b0;
        seg(RPC, 200);
        #1;
        check("t1_en", 32'(inst_sram_en), 1);
        check("t1_addr", inst_sram_addr, RPC);
        check("t1_valid_r0", 32'(if_to_id_valid), 0);
        step(1);
        check("t1_valid_r1", 32'(if_to_id_valid), 0);
        step(1);
        check("t1_valid_r2", 32'(if_to_id_valid), 1);
        check("t1_head_pc", if_to_id_pc, RPC);
        p0 = pop_cnt;
        step(8);
        check("t1_thruput", 32'(pop_cnt - p0), 8);

        // 2: ID stall fills the queue to exactly 4 entries
        stall = 6'b000010;
        step(10);
        #1;
        check("t2_full_en", 32'(inst_sram_en), 0);
        check("t2_full_valid", 32'(if_to_id_valid), 1);
        stall = 6'b000001;
        p0 = pop_cnt;
        step(8);
        check("t2_queued", 32'(pop_cnt - p0), 4);
        check("t2_drained", 32'(if_to_id_valid), 0);
        stall = 6'b000000;
        #1;
        check("t2_resume_en", 32'(inst_sram_en), 1);
        check("t2_resume_addr", inst_sram_addr, exp_q[0].pc);
        step(10);

        // 3: redirect with queued and in-flight words
        stall = 6'b000010;
        step(2);
        stall = 6'b000000;
        br_e = 1'b1; br_addr = 32'hbfc0_0100;
        seg(32'hbfc0_0100, 100);
        step(1);
        br_e = 1'b0;
        #1;
        check("t3_valid_b1", 32'(if_to_id_valid), 0);
        check("t3_en_b1", 32'(inst_sram_en), 1);
        check("t3_addr_b1", inst_sram_addr, 32'hbfc0_0100);
        step(1);
        check("t3_valid_b2", 32'(if_to_id_valid), 0);
        step(1);
        check("t3_valid_b3", 32'(if_to_id_valid), 1);
        check("t3_head_pc", if_to_id_pc, 32'hbfc0_0100);
        step(6);

        // 4: misaligned redirect target
        br_e = 1'b1; br_addr = 32'hbfc0_0102;
        exp_q.delete();
        exp_q.push_back('{pc: 32'hbfc0_0102, inst: 32'h0, excp: 1'b1});
        step(1);
        br_e = 1'b0;
        #1;
        check("t4_no_en", 32'(inst_sram_en), 0);
        e0 = en_cnt;
        step(2);
        check("t4_valid", 32'(if_to_id_valid), 1);
        check("t4_excp", 32'(if_to_id_excp), 1);
        step(6);
        check("t4_halted_en", 32'(en_cnt - e0), 0);
        check("t4_valid_after", 32'(if_to_id_valid), 0);
        check("t4_q_used", 32'(exp_q.size()), 0);

        // 5: fetch stall drains the queue, PC held
        br_e = 1'b1; br_addr = 32'hbfc0_0200;
        seg(32'hbfc0_0200, 100);
        step(1);
        br_e = 1'b0;
        step(6);
        stall = 6'b000001;
        #1;
        e0 = en_cnt;
        step(6);
        check("t5_en_stalled", 32'(en_cnt - e0), 0);
        check("t5_drained", 32'(if_to_id_valid), 0);
        stall = 6'b000000;
        #1;
        check("t5_resume_en", 32'(inst_sram_en), 1);
        check("t5_resume_addr", inst_sram_addr, exp_q[0].pc);
        step(4);
        stall = 6'b000001;
        step(2);
        br_e = 1'b1; br_addr = 32'hbfc0_0300;
        seg(32'hbfc0_0300, 100);
        step(1);
        br_e = 1'b0;
        #1;
        check("t5_br_stall_en", 32'(inst_sram_en), 0);
        step(2);
        stall = 6'b000000;
        #1;
        check("t5_br_resume_en", 32'(inst_sram_en), 1);
        check("t5_br_resume_addr", inst_sram_addr, 32'hbfc0_0300);
        step(6);

        // 6: reset with a full queue
        stall = 6'b000010;
        step(10);
        rst = 1'b1;
        #1;
        check("t6_rst_en", 32'(inst_sram_en), 0);
        step(1);
        rst = 1'b0;
        stall = 6'b000000;
        seg(RPC, 50);
        #1;
        check("t6_valid_r0", 32'(if_to_id_valid), 0);
        check("t6_pc_r0", if_to_id_pc, 0);
        check("t6_en", 32'(inst_sram_en), 1);
        check("t6_addr", inst_sram_addr, RPC);
        step(1);
        check("t6_valid_r1", 32'(if_to_id_valid), 0);
        step(1);
        check("t6_valid_r2", 32'(if_to_id_valid), 1);
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
